// File: rtl/mecobo_pkg.sv
// Shared definitions for the sample sequencer: FSM encoding, command-bus
// register offsets, ctrl bit positions and channel-index width.
package mecobo_pkg;

  localparam int CHAN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_SELECT  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PUSH    = 3'd4
  } state_e;

  localparam logic [15:0] OFF_CTRL    = 16'd0;
  localparam logic [15:0] OFF_MASK_LO = 16'd1;
  localparam logic [15:0] OFF_MASK_HI = 16'd2;

  localparam int CTRL_RUN_BIT     = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  function automatic logic [CHAN_W-1:0] next_ptr(input logic [CHAN_W-1:0] cur,
                                                 input logic [CHAN_W-1:0] last);
    return (cur == last) ? {CHAN_W{1'b0}} : cur + CHAN_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping to the lowest set request when nothing lies at or above ptr_i.
module rr_pick #(
  parameter int N  = 50,
  parameter int IW = 8
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic          hit_hi_s;
  logic [IW-1:0] idx_hi_s;
  logic [IW-1:0] idx_lo_s;

  // Downward scan so the last hit recorded is the lowest index in each region.
  always_comb begin
    hit_hi_s = 1'b0;
    idx_hi_s = {IW{1'b0}};
    idx_lo_s = {IW{1'b0}};
    found_o  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o  = 1'b1;
        idx_lo_s = IW'(i);
        if (IW'(i) >= ptr_i) begin
          hit_hi_s = 1'b1;
          idx_hi_s = IW'(i);
        end else begin
          hit_hi_s = hit_hi_s;
        end
      end else begin
        found_o = found_o;
      end
    end
    if (hit_hi_s) begin
      idx_o = idx_hi_s;
    end else begin
      idx_o = idx_lo_s;
    end
  end

endmodule

// File: rtl/sample_sequencer.sv
// Round-robin sampler that strobes one channel, captures its word and pushes it
// to a FIFO. Define SAMPLE_SEQ_DROP_EN to drop (and count) samples on a full FIFO.
module sample_sequencer
  import mecobo_pkg::*;
#(
  parameter int NUM_CHANNELS = 50,
  parameter int POSITION     = 242
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_bus_en,
  input  logic                    cmd_bus_wr,
  input  logic [15:0]             cmd_bus_addr,
  input  logic [31:0]             cmd_bus_data,
  input  logic [NUM_CHANNELS-1:0] sample_req,
  output logic                    output_sample,
  output logic [7:0]              channel_select,
  input  logic [31:0]             sample_data,
  output logic [31:0]             fifo_din,
  output logic                    fifo_wr_en,
  input  logic                    fifo_full,
  output logic [15:0]             overflow_count,
  output logic                    busy
);

  localparam logic [15:0] ADDR_CTRL    = 16'(POSITION) + OFF_CTRL;
  localparam logic [15:0] ADDR_MASK_LO = 16'(POSITION) + OFF_MASK_LO;
  localparam logic [15:0] ADDR_MASK_HI = 16'(POSITION) + OFF_MASK_HI;
  localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(NUM_CHANNELS - 1);

`ifdef SAMPLE_SEQ_DROP_EN
  localparam logic DROP_EN = 1'b1;
`else
  localparam logic DROP_EN = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic [CHAN_W-1:0]       ptr_q, ptr_d;
  logic [CHAN_W-1:0]       chan_q, chan_d;
  logic                    run_q, run_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                    os_q, os_d;
  logic [31:0]             din_q, din_d;

  logic                    wr_ctrl_s, wr_lo_s, wr_hi_s, clr_ovf_s;
  logic                    found_s;
  logic [CHAN_W-1:0]       grant_s;
  logic [63:0]             mask_wide_s;
  logic                    unused_s;

  assign wr_ctrl_s = cmd_bus_en && cmd_bus_wr && (cmd_bus_addr == ADDR_CTRL);
  assign wr_lo_s   = cmd_bus_en && cmd_bus_wr && (cmd_bus_addr == ADDR_MASK_LO);
  assign wr_hi_s   = cmd_bus_en && cmd_bus_wr && (cmd_bus_addr == ADDR_MASK_HI);
  assign clr_ovf_s = wr_ctrl_s && cmd_bus_data[CTRL_CLR_OVF_BIT];

  rr_pick #(
    .N  (NUM_CHANNELS),
    .IW (CHAN_W)
  ) u_pick (
    .req_i   (sample_req & mask_q),
    .ptr_i   (ptr_q),
    .found_o (found_s),
    .idx_o   (grant_s)
  );

  // Register writes and FSM next-state; registers update at the edge, so a
  // write coinciding with a SCAN decision only affects the following SCAN.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    chan_d      = chan_q;
    os_d        = 1'b0;
    din_d       = din_q;
    mask_wide_s = 64'(mask_q);

    if (wr_ctrl_s) begin
      run_d = cmd_bus_data[CTRL_RUN_BIT];
    end else begin
      run_d = run_q;
    end

    if (wr_lo_s) begin
      mask_wide_s[31:0] = cmd_bus_data;
    end else if (wr_hi_s) begin
      mask_wide_s[63:32] = cmd_bus_data;
    end else begin
      mask_wide_s = 64'(mask_q);
    end
    mask_d = mask_wide_s[NUM_CHANNELS-1:0];

    case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!run_q) begin
          state_d = ST_IDLE;
        end else if (found_s) begin
          state_d = ST_SELECT;
          chan_d  = grant_s;
          os_d    = 1'b1;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SELECT: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_PUSH;
        din_d   = {chan_q, sample_data[23:0]};
      end
      ST_PUSH: begin
        if (!fifo_full || DROP_EN) begin
          ptr_d   = next_ptr(chan_q, LAST_CH);
          state_d = run_q ? ST_SCAN : ST_IDLE;
        end else begin
          state_d = ST_PUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= {CHAN_W{1'b0}};
      chan_q  <= {CHAN_W{1'b0}};
      run_q   <= 1'b0;
      mask_q  <= {NUM_CHANNELS{1'b0}};
      os_q    <= 1'b0;
      din_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      chan_q  <= chan_d;
      run_q   <= run_d;
      mask_q  <= mask_d;
      os_q    <= os_d;
      din_q   <= din_d;
    end
  end

`ifdef SAMPLE_SEQ_DROP_EN
  logic [15:0] ovf_q, ovf_d;

  // Drop counter: a clear beats a same-cycle increment; saturates at all-ones.
  always_comb begin
    if (clr_ovf_s) begin
      ovf_d = 16'h0000;
    end else if ((state_q == ST_PUSH) && fifo_full && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 16'h0000;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_count = ovf_q;
  assign unused_s = ^{sample_data[31:24], mask_wide_s};
`else
  assign overflow_count = 16'h0000;
  assign unused_s = ^{sample_data[31:24], mask_wide_s, clr_ovf_s};
`endif

  assign output_sample  = os_q;
  assign channel_select = chan_q;
  assign fifo_din       = din_q;
  assign fifo_wr_en     = (state_q == ST_PUSH) && !fifo_full;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 50, meaning the number of sampled channels (1..64).
REQ-002 SHALL have parameter POSITION, default 242, meaning the base command-bus address.
REQ-003 SHALL have port clk, input, 1, system clock (sys_clk domain); one clock only.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port cmd_bus_en, input, 1, command-bus strobe.
REQ-006 SHALL have port cmd_bus_wr, input, 1, command-bus write qualifier.
REQ-007 SHALL have port cmd_bus_addr, input, 16, command-bus address.
REQ-008 SHALL have port cmd_bus_data, input, 32, command-bus write data.
REQ-009 SHALL have port sample_req, input, NUM_CHANNELS, per-channel "sample ready" level.
REQ-010 SHALL have port output_sample, output, 1, one-cycle sample-strobe to the selected channel.
REQ-011 SHALL have port channel_select, output, 8, index of the granted channel.
REQ-012 SHALL have port sample_data, input, 32, shared sample bus, driven by the selected channel.
REQ-013 SHALL have port fifo_din, output, 32, sample word to the collector FIFO.
REQ-014 SHALL have port fifo_wr_en, output, 1, FIFO write strobe.
REQ-015 SHALL have port fifo_full, input, 1, FIFO full flag.
REQ-016 SHALL have port overflow_count, output, 16, count of dropped samples.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL decode the command bus only when cmd_bus_en=1 and cmd_bus_wr=1:
- POSITION+0: ctrl; bit0 is run, bit1 is clear-overflow (self-clearing).
- POSITION+1: enable mask[31:0].
- POSITION+2: enable mask[63:32].
- Mask bits at or above NUM_CHANNELS are ignored.
REQ-019 SHALL use the FSM IDLE, SCAN, SELECT, CAPTURE, PUSH.
- IDLE->SCAN when run=1.
- SCAN->SELECT when any channel has sample_req & mask set.
- SELECT->CAPTURE, CAPTURE->PUSH, each unconditionally.
- PUSH->SCAN on write or drop.
REQ-020 SCAN SHALL grant the first qualifying channel at or after rr pointer ptr, wrapping from NUM_CHANNELS-1 to 0.
REQ-021 SELECT SHALL drive output_sample=1 for exactly one cycle, with channel_select equal to the granted index.
REQ-022 CAPTURE SHALL register sample_data and form fifo_din = {channel_select[7:0], sample_data[23:0]}.
REQ-023 PUSH with fifo_full=0 SHALL assert fifo_wr_en for exactly one cycle and set ptr to granted+1, wrapping to 0 at NUM_CHANNELS.
REQ-024 SHALL give a latency of 3 cycles from a qualifying SCAN cycle to fifo_wr_en, when the FIFO is not full.
REQ-025 channel_select SHALL hold its last granted value outside SELECT.
REQ-026 run cleared mid-sample SHALL let the current sample complete through PUSH, then go to IDLE; run cleared in SCAN SHALL go to IDLE next cycle.
REQ-027 A mask or ctrl write in the same cycle as a SCAN decision SHALL take effect from the next SCAN.
REQ-028 Clear-overflow SHALL zero overflow_count; a simultaneous increment SHALL lose to the clear.
REQ-029 A channel with all others idle SHALL be re-granted on consecutive rounds; no channel SHALL be granted twice while another qualifying channel waits.

Reset
REQ-030 While rst=1, all of the following SHALL be 0: state=IDLE, ptr, run, mask, output_sample, channel_select, fifo_din, fifo_wr_en, overflow_count, busy.
REQ-031 rst mid-operation SHALL abort immediately with no trailing fifo_wr_en or output_sample.

Configuration
REQ-032 With SAMPLE_SEQ_DROP_EN defined, PUSH with fifo_full=1 SHALL:
- discard the sample;
- increment overflow_count, saturating at 0xFFFF;
- advance ptr;
- return to SCAN.
REQ-033 Without SAMPLE_SEQ_DROP_EN, PUSH SHALL stall with fifo_din held until fifo_full=0, then write; overflow_count SHALL be constant 0.

Structure
REQ-034 Shared package mecobo_pkg SHALL hold:
- the FSM state encoding;
- address offsets CTRL/MASK_LO/MASK_HI;
- ctrl bit indices;
- channel-index width 8.
REQ-035 The round-robin picker SHALL be a sub-module rr_pick: combinational, inputs are a request vector and ptr, outputs are found and index.

Verification
REQ-036 run=1, mask=all, sample_req[5]=1 only, sample_data=0x00ABCDEF -> output_sample with channel_select=5, then fifo_din=0x05ABCDEF and fifo_wr_en 3 cycles after SCAN.
REQ-037 sample_req[3], [7] and [49] held high -> grant order 3,7,49,3,7 with ptr wrapping at 50.
REQ-038 mask bit 7 cleared, sample_req[7]=1 -> no grant, busy stays in SCAN, fifo_wr_en never asserted.
REQ-039 fifo_full=1 for 10 cycles during PUSH:
- with SAMPLE_SEQ_DROP_EN: one drop, overflow_count=1, no write;
- without it: fifo_wr_en occurs on the first cycle after fifo_full falls.
REQ-040 rst asserted in CAPTURE -> all outputs 0 immediately, and no fifo_wr_en after rst is released with run=0.
